// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through read port,
// a count of buffered delimiter-terminated lines, and a sticky overrun flag.
module uart_rx_fifo #(
    parameter int          DEPTH = 16,
    parameter logic [7:0]  DELIM = 8'h0A
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       rx_valid_i,
    input  logic [7:0]                 rx_byte_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [7:0]                 rd_byte_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [$clog2(DEPTH):0]     line_count_o,
    output logic                       overrun_o,
    input  logic                       clear_overrun_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d, lines_q, lines_d;
    logic          ovr_q, ovr_d;
    logic          push, pop, drop, push_delim, pop_delim;

    assign rd_valid_o   = (count_q != '0);
    assign rd_byte_o    = rd_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o      = count_q;
    assign line_count_o = lines_q;
    assign overrun_o    = ovr_q;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign pop        = rd_valid_o & rd_ready_i;
    assign push       = rx_valid_i & ((count_q != FULL_CNT) | pop);
    assign drop       = rx_valid_i & ~push;
    assign push_delim = push & (rx_byte_i == DELIM);
    assign pop_delim  = pop & (rd_byte_o == DELIM);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lines_d  = lines_q;
        ovr_d    = ovr_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({push_delim, pop_delim})
            2'b10:   lines_d = lines_q + CW'(1);
            2'b01:   lines_d = lines_q - CW'(1);
            default: lines_d = lines_q;
        endcase

        // Set wins over clear so a drop in the clearing cycle is never lost.
        if (drop)                 ovr_d = 1'b1;
        else if (clear_overrun_i) ovr_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            lines_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            lines_q  <= lines_d;
            ovr_q    <= ovr_d;
        end
    end

    // NOTE: storage is not reset; contents are only visible once count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= rx_byte_i;
    end
endmodule
